// File: rtl/fetch_prefetcher.sv
// rtl/fetch_prefetcher.sv - instruction prefetcher: one-outstanding memory request FSM feeding an instruction FIFO
// Define FETCH_PREFETCH_EN to prefetch up to FIFO_DEPTH entries; otherwise fetch one instruction at a time.
module fetch_prefetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             redirect_valid,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] redirect_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic                             instr_valid,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instr_data,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] instr_pc,
    input  logic                             instr_ready,
    output logic                             busy
);
    localparam int AW    = PROGRAM_MEM_ADDR_BITS;
    localparam int DW    = PROGRAM_MEM_DATA_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [AW-1:0]    PC_ONE  = AW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Issue happens only from IDLE, so nothing is in flight and occupancy alone bounds the buffer.
`ifdef FETCH_PREFETCH_EN
    localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(FIFO_DEPTH);
`else
    localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(1);
`endif

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             stale_q, stale_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] fifo_pc_q   [FIFO_DEPTH];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        stale_d    = stale_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !redirect_valid && (count_q < ISSUE_LIMIT)) begin
                    state_d    = REQ;
                    addr_d     = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_ONE;
                end
            end
            REQ: begin
                if (mem_read_ready) begin
                    state_d = ACK;
                    push    = !stale_q && !redirect_valid;
                end
            end
            ACK: begin
                if (!mem_read_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if (state_q != IDLE) stale_d = 1'b1;
        end
        if (state_d == IDLE) stale_d = 1'b0;
    end

    always_comb begin
        pop      = (count_q != '0) && instr_ready && !redirect_valid;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            addr_q     <= '0;
            stale_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_read_data;
            fifo_pc_q[wr_ptr_q]   <= addr_q;
        end
    end

    assign mem_read_valid   = (state_q == REQ);
    assign mem_read_address = addr_q;
    assign busy             = (state_q != IDLE);
    assign instr_valid      = (count_q != '0);
    assign instr_data       = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc         = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_prefetcher.sv
// tb/tb_fetch_prefetcher.sv - self-checking bench for fetch_prefetcher
// Model: after each redirect/reset to P, issued and delivered PCs run P, P+1, ... with data = pc + 0x100.
module tb_fetch_prefetcher;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef FETCH_PREFETCH_EN
    localparam int EFF = DEPTH;
`else
    localparam int EFF = 1;
`endif

    typedef struct {
        bit            mark;
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready = 1'b0;
    logic [DW-1:0] mem_read_data = '0;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    int   lat_cfg = 2;
    int   hold_cfg = 0;
    bit   rand_mem = 1'b0;
    rec_t req_q[$];
    rec_t pop_q[$];
    int   viol_hold = 0, viol_rise = 0, viol_busy = 0;
    int   issues_since = 0, pops_since = 0, inflight_max = 0;

    fetch_prefetcher #(
        .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // Memory controller: answers addr+0x100 after a latency, optionally holding ready past the drop of valid.
    initial begin : responder
        int wcnt, hcnt, cur_lat;
        wcnt = 0; hcnt = 0; cur_lat = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_read_ready = 1'b0; wcnt = 0; hcnt = 0;
            end else if (mem_read_ready) begin
                if (hcnt == 0) begin
                    mem_read_ready = 1'b0;
                    mem_read_data  = DW'($urandom);
                end else hcnt--;
            end else if (mem_read_valid) begin
                if (wcnt == 0) cur_lat = rand_mem ? int'($urandom_range(lat_cfg, 0)) : lat_cfg;
                if (wcnt >= cur_lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = DW'(mem_read_address) + 16'h0100;
                    hcnt = rand_mem ? int'($urandom_range(hold_cfg, 0)) : hold_cfg;
                    wcnt = 0;
                end else wcnt++;
            end
        end
    end

    initial begin : monitor
        logic pv, pr, prst;
        logic [AW-1:0] pa;
        pv = 1'b0; pr = 1'b0; prst = 1'b1; pa = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                req_q.push_back('{mark: 1'b1, pc: '0, data: '0});
                pop_q.push_back('{mark: 1'b1, pc: '0, data: '0});
                issues_since = 0; pops_since = 0;
            end else begin
                if (mem_read_valid && !pv) begin
                    req_q.push_back('{mark: 1'b0, pc: mem_read_address, data: '0});
                    issues_since++;
                end
                if (instr_valid && instr_ready && !redirect_valid) begin
                    pop_q.push_back('{mark: 1'b0, pc: instr_pc, data: instr_data});
                    pops_since++;
                end
                if (redirect_valid) begin
                    req_q.push_back('{mark: 1'b1, pc: redirect_pc, data: '0});
                    pop_q.push_back('{mark: 1'b1, pc: redirect_pc, data: '0});
                    issues_since = 0; pops_since = 0;
                end
                if (issues_since - pops_since > inflight_max) inflight_max = issues_since - pops_since;
                if (!prst) begin
                    if (pv && !pr && !(mem_read_valid && mem_read_address == pa)) viol_hold++;
                    if (mem_read_valid && !pv && pr) viol_rise++;
                    if (mem_read_valid && !busy) viol_busy++;
                end
            end
            pv = mem_read_valid; pr = mem_read_ready; pa = mem_read_address; prst = reset;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (mem_read_valid && !mem_read_ready) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        cyc(3);
        @(negedge clk);
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_read_valid); end
        checks++; if (mem_read_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", mem_read_address); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b want 0", instr_valid); end
        checks++; if (instr_data !== 16'h0000) begin errors++; $display("FAIL reset_idata: got %h want 0000", instr_data); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_ipc: got %h want 00", instr_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        cyc(1); reset = 1'b0;
        cyc(2);
        @(negedge clk);
        checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL idle_disabled: got %b want 0", mem_read_valid); end
    endtask

    task automatic test_fill_stall;
        req_q.delete(); pop_q.delete();
        lat_cfg = 2; hold_cfg = 0; rand_mem = 1'b0;
        cyc(1); enable = 1'b1;
        cyc(60);
        @(negedge clk);
        checks++; if (req_q.size() !== EFF) begin errors++; $display("FAIL fill_count: got %0d want %0d", req_q.size(), EFF); end
        for (int i = 0; i < req_q.size() && i < EFF; i++) begin
            checks++;
            if (req_q[i].mark || req_q[i].pc !== AW'(i)) begin errors++; $display("FAIL fill_req[%0d]: got %h want %h", i, req_q[i].pc, AW'(i)); end
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fill_ivalid: got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL fill_ipc: got %h want 00", instr_pc); end
        checks++; if (instr_data !== 16'h0100) begin errors++; $display("FAIL fill_idata: got %h want 0100", instr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy: got %b want 0", busy); end
    endtask

    task automatic test_pop_one;
        req_q.delete(); pop_q.delete();
        cyc(1); instr_ready = 1'b1;
        cyc(1); instr_ready = 1'b0;
        cyc(30);
        @(negedge clk);
        checks++; if (pop_q.size() !== 1) begin errors++; $display("FAIL pop_count: got %0d want 1", pop_q.size()); end
        else begin
            checks++; if (pop_q[0].pc !== 8'h00 || pop_q[0].data !== 16'h0100) begin errors++; $display("FAIL pop_head: got %h/%h want 00/0100", pop_q[0].pc, pop_q[0].data); end
        end
        checks++; if (req_q.size() !== 1) begin errors++; $display("FAIL refill_count: got %0d want 1", req_q.size()); end
        else begin
            checks++; if (req_q[0].pc !== AW'(EFF)) begin errors++; $display("FAIL refill_addr: got %h want %h", req_q[0].pc, AW'(EFF)); end
        end
        checks++; if (instr_pc !== 8'h01 || instr_data !== 16'h0101) begin errors++; $display("FAIL refill_head: got %h/%h want 01/0101", instr_pc, instr_data); end
    endtask

    task automatic test_redirect_req;
        bit ok; logic [AW-1:0] xaddr, exp_pc; int npost; bit seen;
        req_q.delete(); pop_q.delete();
        lat_cfg = 6;
        cyc(1); instr_ready = 1'b1;
        cyc(1); instr_ready = 1'b0;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL redir_wait: got no request want one"); end
        xaddr = mem_read_address;
        checks++; if (xaddr !== AW'(EFF + 1)) begin errors++; $display("FAIL redir_stale_addr: got %h want %h", xaddr, AW'(EFF + 1)); end
        cyc(1); redirect_valid = 1'b1; redirect_pc = 8'h40;
        cyc(1); redirect_valid = 1'b0; lat_cfg = 2; instr_ready = 1'b1;
        cyc(60); instr_ready = 1'b0;
        cyc(2);
        checks++;
        if (req_q.size() < 3 || req_q[0].pc !== xaddr || !req_q[1].mark || req_q[2].pc !== 8'h40) begin
            errors++; $display("FAIL redir_req_seq: got %0d entries want stale %h then 40", req_q.size(), xaddr);
        end
        exp_pc = 8'h01; npost = 0; seen = 1'b0;
        foreach (pop_q[i]) begin
            if (pop_q[i].mark) begin exp_pc = pop_q[i].pc; seen = 1'b1; end
            else begin
                checks++;
                if (pop_q[i].pc !== exp_pc || pop_q[i].data !== DW'(exp_pc) + 16'h0100) begin
                    errors++; $display("FAIL redir_pop[%0d]: got %h/%h want %h/%h", i, pop_q[i].pc, pop_q[i].data, exp_pc, DW'(exp_pc) + 16'h0100);
                end
                if (seen) npost++;
                exp_pc = exp_pc + 8'd1;
            end
        end
        checks++; if (npost < 2) begin errors++; $display("FAIL redir_delivered: got %0d want >=2", npost); end
    endtask

    task automatic test_wrap;
        int k; logic [AW-1:0] want;
        req_q.delete(); pop_q.delete();
        lat_cfg = 2; rand_mem = 1'b1; hold_cfg = 0;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        cyc(1); redirect_valid = 1'b0; instr_ready = 1'b1;
        cyc(60);
        k = -1;
        foreach (req_q[i]) if (req_q[i].mark && k < 0) k = i;
        for (int j = 0; j < 4; j++) begin
            want = 8'hFE + AW'(j);
            checks++;
            if (k < 0 || k + 1 + j >= req_q.size() || req_q[k + 1 + j].pc !== want) begin
                errors++; $display("FAIL wrap_req[%0d]: missing or wrong, want %h", j, want);
            end
        end
        k = -1;
        foreach (pop_q[i]) if (pop_q[i].mark && k < 0) k = i;
        for (int j = 0; j < 4; j++) begin
            want = 8'hFE + AW'(j);
            checks++;
            if (k < 0 || k + 1 + j >= pop_q.size() || pop_q[k + 1 + j].pc !== want || pop_q[k + 1 + j].data !== DW'(want) + 16'h0100) begin
                errors++; $display("FAIL wrap_pop[%0d]: missing or wrong, want %h", j, want);
            end
        end
        rand_mem = 1'b0;
    endtask

    task automatic test_ready_hold;
        bit found;
        req_q.delete();
        lat_cfg = 1; hold_cfg = 3; rand_mem = 1'b0; instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mem_read_ready && !mem_read_valid) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL hold_seen: got no held ready want one"); end
        for (int i = 0; i < 10 && mem_read_ready; i++) begin
            checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b want 0 while ready high", mem_read_valid); end
            @(negedge clk);
        end
        checks++; if (mem_read_ready !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", mem_read_ready); end
        cyc(40);
        checks++; if (req_q.size() < 3) begin errors++; $display("FAIL hold_progress: got %0d want >=3", req_q.size()); end
    endtask

    task automatic test_enable_low;
        bit ok; logic [AW-1:0] xaddr;
        pop_q.delete();
        lat_cfg = 5; hold_cfg = 0; enable = 1'b1; instr_ready = 1'b1;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_wait: got no request want one"); end
        xaddr = mem_read_address;
        cyc(1); enable = 1'b0; req_q.delete();
        cyc(30);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
        checks++; if (req_q.size() !== 0) begin errors++; $display("FAIL en_blocked: got %0d requests want 0", req_q.size()); end
        checks++;
        if (pop_q.size() == 0 || pop_q[pop_q.size() - 1].pc !== xaddr || pop_q[pop_q.size() - 1].data !== DW'(xaddr) + 16'h0100) begin
            errors++; $display("FAIL en_complete: last delivered wrong, want %h", xaddr);
        end
    endtask

    task automatic test_reset_mid;
        bit ok; int k;
        req_q.delete();
        lat_cfg = 8; instr_ready = 1'b0; enable = 1'b1;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_wait: got no request want one"); end
        cyc(1); reset = 1'b1;
        cyc(1); reset = 1'b0;
        @(negedge clk);
        checks++; if (mem_read_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abandon: got valid %b busy %b want 0 0", mem_read_valid, busy); end
        checks++; if (mem_read_address !== 8'h00 || instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_clear: got addr %h ivalid %b want 00 0", mem_read_address, instr_valid); end
        lat_cfg = 2;
        cyc(30);
        @(negedge clk);
        checks++; if (instr_pc !== 8'h00 || instr_data !== 16'h0100) begin errors++; $display("FAIL rmid_head: got %h/%h want 00/0100", instr_pc, instr_data); end
        k = -1;
        foreach (req_q[i]) if (req_q[i].mark) k = i;
        checks++; if (k < 0 || k + 1 >= req_q.size() || req_q[k + 1].pc !== 8'h00) begin errors++; $display("FAIL rmid_restart: first request after reset wrong, want 00"); end
    endtask

    task automatic test_random;
        logic [AW-1:0] exp_pc; int npop;
        req_q.delete(); pop_q.delete();
        enable = 1'b0; reset = 1'b1;
        cyc(2); reset = 1'b0;
        lat_cfg = 3; hold_cfg = 2; rand_mem = 1'b1;
        for (int c = 0; c < 600; c++) begin
            enable         = ($urandom_range(9, 0) != 0);
            instr_ready    = 1'($urandom_range(1, 0));
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = AW'($urandom);
            cyc(1);
        end
        redirect_valid = 1'b0; enable = 1'b0; instr_ready = 1'b1;
        cyc(40);
        exp_pc = '0;
        foreach (req_q[i]) begin
            if (req_q[i].mark) exp_pc = req_q[i].pc;
            else begin
                checks++;
                if (req_q[i].pc !== exp_pc) begin errors++; $display("FAIL rand_req[%0d]: got %h want %h", i, req_q[i].pc, exp_pc); end
                exp_pc = exp_pc + 8'd1;
            end
        end
        exp_pc = '0; npop = 0;
        foreach (pop_q[i]) begin
            if (pop_q[i].mark) exp_pc = pop_q[i].pc;
            else begin
                checks++;
                if (pop_q[i].pc !== exp_pc || pop_q[i].data !== DW'(exp_pc) + 16'h0100) begin
                    errors++; $display("FAIL rand_pop[%0d]: got %h/%h want %h/%h", i, pop_q[i].pc, pop_q[i].data, exp_pc, DW'(exp_pc) + 16'h0100);
                end
                exp_pc = exp_pc + 8'd1; npop++;
            end
        end
        checks++; if (npop < 20) begin errors++; $display("FAIL rand_throughput: got %0d pops want >=20", npop); end
        rand_mem = 1'b0;
    endtask

    task automatic test_protocol;
        checks++; if (viol_hold !== 0) begin errors++; $display("FAIL proto_hold: got %0d unstable requests want 0", viol_hold); end
        checks++; if (viol_rise !== 0) begin errors++; $display("FAIL proto_rise: got %0d issues under ready want 0", viol_rise); end
        checks++; if (viol_busy !== 0) begin errors++; $display("FAIL proto_busy: got %0d want 0", viol_busy); end
        checks++; if (inflight_max > EFF) begin errors++; $display("FAIL proto_depth: got %0d in flight want <=%0d", inflight_max, EFF); end
    endtask

    initial begin
        test_reset;
        test_fill_stall;
        test_pop_one;
        test_redirect_req;
        test_wrap;
        test_ready_hold;
        test_enable_low;
        test_reset_mid;
        test_random;
        test_protocol;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
